// File: rtl/mac_tile_ms.sv
// Dual-mode systolic MAC tile. In weight-stationary mode it holds one weight and adds its
// product to the psum from north. In output-stationary mode it accumulates locally and drains south.
module mac_tile_ms #(
  parameter int bw      = 4,
  parameter int psum_bw = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [bw-1:0]      in_w,
  output logic [bw-1:0]      out_e,
  input  logic [2:0]         inst_w,
  output logic [2:0]         inst_e,
  input  logic [psum_bw-1:0] in_n,
  output logic [psum_bw-1:0] out_s
);

  typedef enum logic {
    MODE_WS = 1'b0,
    MODE_OS = 1'b1
  } mode_e;

  logic [bw-1:0]      a_q, a_d;
  logic [bw-1:0]      b_q, b_d;
  logic [psum_bw-1:0] c_q, c_d;
  logic [psum_bw-1:0] acc_q, acc_d;
  logic [2:0]         inst_q, inst_d;
  logic               load_ready_q, load_ready_d;
  mode_e              mode_q, mode_d;
  logic               exec_q, exec_d;

  logic [psum_bw-1:0] a_ext;
  logic [psum_bw-1:0] b_ext;
  logic [psum_bw-1:0] prod;
  mode_e              mode_in;

  assign mode_in = mode_e'(mode);

  // Activation is unsigned and the weight signed; the low psum_bw bits of the
  // unsigned product of the extended operands are the wrapped signed result.
  always_comb begin
    a_ext = {{(psum_bw-bw){1'b0}}, a_q};
    b_ext = {{(psum_bw-bw){b_q[bw-1]}}, b_q};
    prod  = a_ext * b_ext;
  end

  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    acc_d        = acc_q;
    inst_d       = inst_q;
    load_ready_d = load_ready_q;
    mode_d       = mode_q;
    exec_d       = exec_q;

    if (mode_in != mode_q) begin
      mode_d       = mode_in;
      b_d          = '0;
      acc_d        = '0;
      c_d          = '0;
      load_ready_d = 1'b1;
    end else if (mode_q == MODE_WS) begin
      if (inst_w[0] || inst_w[1]) begin
        a_d = in_w;
      end
      c_d = in_n;
      // The first load pulse is swallowed here so the next tile east sees the following weight.
      if (inst_w[0] && load_ready_q) begin
        b_d          = in_w;
        load_ready_d = 1'b0;
      end
      inst_d = {1'b0, inst_w[1], inst_w[0] & ~load_ready_q};
    end else begin
      inst_d = inst_w;
      if (inst_w[2]) begin
        acc_d  = in_n;
        exec_d = 1'b0;
      end else if (inst_w[0]) begin
        acc_d  = '0;
        exec_d = 1'b0;
      end else begin
        if (exec_q) begin
          acc_d = acc_q + prod;
        end
        if (inst_w[1]) begin
          a_d    = in_w;
          b_d    = in_n[bw-1:0];
          exec_d = 1'b1;
        end else begin
          exec_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      acc_q        <= '0;
      inst_q       <= '0;
      load_ready_q <= 1'b1;
      mode_q       <= mode_in;
      exec_q       <= 1'b0;
    end else begin
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      acc_q        <= acc_d;
      inst_q       <= inst_d;
      load_ready_q <= load_ready_d;
      mode_q       <= mode_d;
      exec_q       <= exec_d;
    end
  end

  // In OS mode the drain path is combinational from inst_w so a column shifts one tile per cycle.
  always_comb begin
    out_s = c_q + prod;
    if (mode_q == MODE_OS) begin
      if (inst_w[2]) begin
        out_s = acc_q;
      end else begin
        out_s = {{(psum_bw-bw){1'b0}}, b_q};
      end
    end
  end

  assign out_e  = a_q;
  assign inst_e = inst_q;

endmodule

// File: tb/tb_mac_tile_ms.sv
// Bench for mac_tile_ms: a 16-bit and an 8-bit psum tile driven in lockstep and compared every
// cycle against a full-precision integer model, plus directed scenarios with hand-computed values.
module tb_mac_tile_ms;

  logic        clk;
  logic        reset;
  logic        mode;
  logic [3:0]  in_w;
  logic [2:0]  inst_w;
  logic [15:0] in_n;

  logic [3:0]  out_e16, out_e8;
  logic [2:0]  inst_e16, inst_e8;
  logic [15:0] out_s16;
  logic [7:0]  out_s8;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  mac_tile_ms #(.bw(4), .psum_bw(16)) dut16 (
    .clk(clk), .reset(reset), .mode(mode), .in_w(in_w), .out_e(out_e16),
    .inst_w(inst_w), .inst_e(inst_e16), .in_n(in_n), .out_s(out_s16)
  );

  mac_tile_ms #(.bw(4), .psum_bw(8)) dut8 (
    .clk(clk), .reset(reset), .mode(mode), .in_w(in_w), .out_e(out_e8),
    .inst_w(inst_w), .inst_e(inst_e8), .in_n(in_n[7:0]), .out_s(out_s8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: the accumulator and psum are kept as wide integers and
  // masked to each tile's width only when compared.
  int         m_act    = 0;
  int         m_c      = 0;
  int         m_acc    = 0;
  int         m_prod   = 0;
  logic [3:0] m_wbits  = '0;
  logic [2:0] m_inst   = '0;
  logic       m_mode   = 1'b0;
  logic       m_ready  = 1'b1;
  logic       m_pend   = 1'b0;

  function automatic int sx4(input logic [3:0] v);
    return v[3] ? int'(v) - 16 : int'(v);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_mode  <= mode;
      m_act   <= 0;
      m_c     <= 0;
      m_acc   <= 0;
      m_prod  <= 0;
      m_wbits <= '0;
      m_inst  <= '0;
      m_ready <= 1'b1;
      m_pend  <= 1'b0;
    end else if (mode != m_mode) begin
      m_mode  <= mode;
      m_wbits <= '0;
      m_acc   <= 0;
      m_c     <= 0;
      m_ready <= 1'b1;
    end else if (!m_mode) begin
      m_inst <= {1'b0, inst_w[1], inst_w[0] & ~m_ready};
      if (inst_w[0] || inst_w[1]) m_act <= int'(in_w);
      m_c <= int'(in_n);
      if (inst_w[0] && m_ready) begin
        m_wbits <= in_w;
        m_ready <= 1'b0;
      end
    end else begin
      m_inst <= inst_w;
      if (inst_w[2]) begin
        m_acc  <= int'(in_n);
        m_pend <= 1'b0;
      end else if (inst_w[0]) begin
        m_acc  <= 0;
        m_pend <= 1'b0;
      end else begin
        m_acc <= m_pend ? m_acc + m_prod : m_acc;
        if (inst_w[1]) begin
          m_act   <= int'(in_w);
          m_wbits <= in_n[3:0];
          m_prod  <= int'(in_w) * sx4(in_n[3:0]);
          m_pend  <= 1'b1;
        end else begin
          m_pend <= 1'b0;
        end
      end
    end
  end

  function automatic int expOutS();
    if (m_mode && inst_w[2]) return m_acc;
    if (m_mode) return int'(m_wbits);
    return m_c + m_act * sx4(m_wbits);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("out_s16", int'(out_s16), expOutS() & 32'h0000FFFF);
      checkOutput("out_s8",  int'(out_s8),  expOutS() & 32'h000000FF);
      checkOutput("out_e16", int'(out_e16), m_act);
      checkOutput("inst_e16", int'(inst_e16), int'(m_inst));
      checkOutput("out_e8",  int'(out_e8),  m_act);
      checkOutput("inst_e8", int'(inst_e8), int'(m_inst));
    end
  end

  // Inputs change just after a rising edge; the task returns mid-cycle so
  // directed checks see registers from that edge plus the inputs just applied.
  task automatic applyStimulus(input logic rst, input logic m, input logic [2:0] inst,
                               input logic [3:0] w, input logic [15:0] n);
    @(posedge clk);
    #1;
    reset  = rst;
    mode   = m;
    inst_w = inst;
    in_w   = w;
    in_n   = n;
    #3;
  endtask

  logic [2:0] r_inst;
  logic       r_mode;
  logic       r_rst;
  logic [2:0] prev_inst;

  initial begin
    reset = 1'b1; mode = 1'b0; inst_w = '0; in_w = '0; in_n = '0;

    applyStimulus(1'b1, 1'b0, 3'($urandom), 4'($urandom), 16'($urandom));
    applyStimulus(1'b1, 1'b0, 3'($urandom), 4'($urandom), 16'($urandom));
    checkOutput("rst_out_s16", int'(out_s16), 0);
    checkOutput("rst_out_s8", int'(out_s8), 0);
    checkOutput("rst_out_e", int'(out_e16), 0);
    checkOutput("rst_inst_e", int'(inst_e16), 0);
    checkOutput("rst_load_ready", int'(dut16.load_ready_q), 1);
    chk_en = 1'b1;

    // WS weight load: first pulse captured locally, second forwarded east
    applyStimulus(1'b0, 1'b0, 3'b001, 4'd3, 16'd0);
    applyStimulus(1'b0, 1'b0, 3'b001, 4'd5, 16'd0);
    checkOutput("ws_load1_out_e", int'(out_e16), 3);
    checkOutput("ws_load1_inst_e", int'(inst_e16), 0);
    applyStimulus(1'b0, 1'b0, 3'b000, 4'd0, 16'd0);
    checkOutput("ws_load2_out_e", int'(out_e16), 5);
    checkOutput("ws_load2_inst_e", int'(inst_e16), 1);
    applyStimulus(1'b0, 1'b0, 3'b001, 4'd9, 16'd0);
    applyStimulus(1'b0, 1'b0, 3'b000, 4'd0, 16'd0);
    checkOutput("ws_weight_kept", int'(dut16.b_q), 3);
    checkOutput("ws_load3_out_e", int'(out_e16), 9);

    // WS execute: 100 + 7*3 = 121
    applyStimulus(1'b0, 1'b0, 3'b010, 4'd7, 16'd100);
    applyStimulus(1'b0, 1'b0, 3'b000, 4'd0, 16'd0);
    checkOutput("ws_exec_pos", int'(out_s16), 121);

    // WS execute with weight -2: 100 - 14 = 86
    applyStimulus(1'b1, 1'b0, 3'b000, 4'd0, 16'd0);
    applyStimulus(1'b0, 1'b0, 3'b001, 4'hE, 16'd0);
    applyStimulus(1'b0, 1'b0, 3'b010, 4'd7, 16'd100);
    applyStimulus(1'b0, 1'b0, 3'b000, 4'd0, 16'd0);
    checkOutput("ws_exec_neg16", int'(out_s16), 86);
    checkOutput("ws_exec_neg8", int'(out_s8), 86);

    // OS: 1*2 + 2*3 + 3*(-1) + 15*7 = 110
    applyStimulus(1'b0, 1'b1, 3'b000, 4'd0, 16'd0);
    applyStimulus(1'b0, 1'b1, 3'b001, 4'd0, 16'd0);
    applyStimulus(1'b0, 1'b1, 3'b010, 4'd1, 16'd2);
    applyStimulus(1'b0, 1'b1, 3'b010, 4'd2, 16'd3);
    applyStimulus(1'b0, 1'b1, 3'b010, 4'd3, 16'h000F);
    applyStimulus(1'b0, 1'b1, 3'b010, 4'd15, 16'd7);
    applyStimulus(1'b0, 1'b1, 3'b000, 4'd0, 16'd0);
    checkOutput("os_weight_pass", int'(out_s16), 7);
    applyStimulus(1'b0, 1'b1, 3'b100, 4'd0, 16'h1234);
    checkOutput("os_drain_acc", int'(out_s16), 110);
    applyStimulus(1'b0, 1'b1, 3'b100, 4'd0, 16'd0);
    checkOutput("os_drain_chain16", int'(out_s16), 16'h1234);
    checkOutput("os_drain_chain8", int'(out_s8), 8'h34);

    // Wrap: 3 * 105 = 315, which is 59 in an 8-bit accumulator
    applyStimulus(1'b0, 1'b1, 3'b001, 4'd0, 16'd0);
    applyStimulus(1'b0, 1'b1, 3'b010, 4'd15, 16'd7);
    applyStimulus(1'b0, 1'b1, 3'b010, 4'd15, 16'd7);
    applyStimulus(1'b0, 1'b1, 3'b010, 4'd15, 16'd7);
    applyStimulus(1'b0, 1'b1, 3'b000, 4'd0, 16'd0);
    applyStimulus(1'b0, 1'b1, 3'b100, 4'd0, 16'd0);
    checkOutput("os_wrap8", int'(out_s8), 59);
    checkOutput("os_nowrap16", int'(out_s16), 315);

    // Execute together with drain: drain wins, operands not captured
    applyStimulus(1'b0, 1'b1, 3'b110, 4'd9, 16'h0055);
    checkOutput("os_exdrain_out", int'(out_s16), 0);
    applyStimulus(1'b0, 1'b1, 3'b100, 4'd0, 16'd0);
    checkOutput("os_exdrain_acc", int'(out_s16), 16'h0055);
    checkOutput("os_exdrain_a", int'(out_e16), 15);

    // Mode switch OS -> WS clears accumulator and weight, reopens loading
    applyStimulus(1'b0, 1'b1, 3'b010, 4'd2, 16'd3);
    applyStimulus(1'b0, 1'b1, 3'b000, 4'd0, 16'd0);
    applyStimulus(1'b0, 1'b1, 3'b000, 4'd0, 16'd0);
    checkOutput("sw_acc_before", int'(dut16.acc_q), 6);
    applyStimulus(1'b0, 1'b0, 3'b000, 4'd0, 16'd0);
    applyStimulus(1'b0, 1'b0, 3'b000, 4'd0, 16'd0);
    checkOutput("sw_acc_cleared", int'(dut16.acc_q), 0);
    checkOutput("sw_b_cleared", int'(dut16.b_q), 0);
    checkOutput("sw_load_ready", int'(dut16.load_ready_q), 1);
    checkOutput("sw_out_s", int'(out_s16), 0);
    applyStimulus(1'b0, 1'b0, 3'b001, 4'd6, 16'd0);
    applyStimulus(1'b0, 1'b0, 3'b010, 4'd2, 16'd10);
    applyStimulus(1'b0, 1'b0, 3'b000, 4'd0, 16'd0);
    checkOutput("sw_new_weight", int'(out_s16), 22);

    // Random traffic. Drains and mode switches never directly follow an execute,
    // and mode switches carry no instruction.
    prev_inst = 3'b000;
    r_mode    = 1'b0;
    for (int i = 0; i < 600; i++) begin
      r_rst  = ($urandom_range(0, 99) == 0);
      r_inst = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) r_inst = 3'b010;
      if (!r_rst && !prev_inst[1] && $urandom_range(0, 24) == 0) begin
        r_mode = ~r_mode;
        r_inst = 3'b000;
      end
      if (r_inst[2] && prev_inst[1]) r_inst[2] = 1'b0;
      applyStimulus(r_rst, r_mode, r_inst, 4'($urandom), 16'($urandom));
      prev_inst = r_inst;
    end
    applyStimulus(1'b0, r_mode, 3'b000, 4'd0, 16'd0);
    applyStimulus(1'b0, r_mode, 3'b000, 4'd0, 16'd0);

    @(posedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
